nock_program_loader: RTL
========================

Name: nock_program_loader

Overview:
- Upstream stage of the NockPU core: receives a byte-serial program image, assembles memory words and writes them into memory_unit through the standard func/execute/mem_ready handshake.
- Replaces the simulation-only hex preload.
- On completion, holds the memory-mux ownership released and raises the start request plus start address consumed by mem_traversal (its execute and start_addr inputs).

Parameters:
- ADDR_W, 10: memory address width; equals `memory_addr_width`.
- DATA_W, 64: memory word width; equals `memory_data_width`.
- BASE_ADDR, 0: address of the first loaded word.
- START_ADDR, 1: value driven on start_addr after load.
- MEM_FUNC_WRITE, 2'b01: mem_func code for a write.
- BYTES_PER_WORD, (DATA_W+7)/8: derived; bytes per word.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  program byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready).
- mem_ready  in  1  memory_unit ready.
- mem_execute  out  1  one-cycle memory request strobe.
- mem_func  out  2  memory function.
- address  out  ADDR_W  write address.
- write_data  out  DATA_W  write word.
- mem_owner  out  1  1 = loader drives memory (mux steering), 0 = released to core.
- traversal_execute  out  1  start request to mem_traversal (level).
- start_addr  out  ADDR_W  root address for traversal.
- loaded  out  1  load complete.
- error  out  1  sticky load error.
- words_written  out  16  count of completed writes.

Behaviour:
Reset values (rst low, asynchronous):
- in_ready=0, mem_execute=0, mem_func=0, address=0, write_data=0, mem_owner=1.
- traversal_execute=0, start_addr=0, loaded=0, error=0, words_written=0, state=HDR_HI.

Frame format:
- 16-bit word count N, big-endian.
- Then N words, each BYTES_PER_WORD bytes, MSB first.
- For the top byte, bits above DATA_W are discarded.
- Word k is written to BASE_ADDR+k.

States and transitions:
- HDR_HI: in_ready=1; on transfer, latch N[15:8] → HDR_LO.
- HDR_LO: in_ready=1; on transfer, latch N[7:0] → CHECK.
- CHECK (1 cycle, in_ready=0):
  - If N > 2^ADDR_W − BASE_ADDR → ERROR.
  - Else if N=0 → DONE.
  - Else → COLLECT.
- COLLECT: in_ready=1; shift byte into word register, byte counter +1. On the last byte of a word → WR_REQ. in_ready is 0 on the following cycle.
- WR_REQ: in_ready=0; wait for mem_ready=1, then assert mem_execute for exactly one cycle. address, write_data and mem_func=MEM_FUNC_WRITE are valid that cycle and held until the write completes → WR_BUSY.
- WR_BUSY: wait mem_ready=0 → WR_DONE.
- WR_DONE: wait mem_ready=1; then words_written+1, address+1.
  - If words_written == N → DONE.
  - Else → COLLECT.
- DONE (terminal until reset):
  - First cycle: mem_owner=0 and start_addr=START_ADDR.
  - Next cycle: traversal_execute=1 and loaded=1, held high until reset.
  - in_ready=0 and mem_execute=0 permanently.
- ERROR (terminal until reset): error=1, in_ready=0, mem_owner=1, traversal_execute=0.

Timing and boundary rules:
- The memory request is never issued while mem_ready=0. Latency from last byte to mem_execute is 1 cycle when mem_ready is already high.
- in_valid low mid-word: stall, no timeout; the partial word is retained.
- Bytes presented after DONE/ERROR are not accepted (in_ready=0).
- Address arithmetic is ADDR_W wide. CHECK guarantees no wrap, so the last address is BASE_ADDR+N−1 ≤ 2^ADDR_W−1.
- N = 2^ADDR_W − BASE_ADDR is legal (fills memory exactly).
- Reset asserted mid-write: all outputs return to reset values immediately, the memory request is dropped, and the next frame restarts at HDR_HI.
- mem_owner never falls before the final write's mem_ready has returned high.

Test Plan:
1. BYTES_PER_WORD=8, frame 00 02 + 0x0000000000000011 + 0xAAAAAAAAAAAAAAAA, memory with 3-cycle busy → two writes: address 0 ← 0x11, address 1 ← 0xAAAA_AAAA_AAAA_AAAA. words_written=2, then mem_owner=0, start_addr=1, next cycle traversal_execute=1 and loaded=1.
2. Frame 00 00 → no mem_execute pulses; DONE within 4 cycles of the second byte; traversal_execute=1.
3. ADDR_W=10, BASE_ADDR=0, header 04 01 (N=1025) → error=1 after CHECK; no mem_execute; in_ready=0 forever.
4. in_valid toggled randomly with gaps of 0–5 cycles during 3 words, mem_ready held low 10 cycles before each write → written data is bit-exact; exactly one mem_execute per word, never while mem_ready=0.
5. rst driven low during WR_BUSY of word 2, then released; fresh frame 00 01 + word 0x5 → address 0 ← 0x5, words_written=1, loaded=1.
6. BASE_ADDR=1020, N=4 → last write at address 1023, no error. N=5 → error=1.

Source files
------------

// File: rtl/nock_program_loader.sv
// rtl/nock_program_loader.sv - byte-serial program image loader feeding memory_unit writes
// Owns the memory mux until the image is written, then hands off to mem_traversal.
module nock_program_loader #(
  parameter int          ADDR_W         = 10,
  parameter int          DATA_W         = 64,
  parameter int          BASE_ADDR      = 0,
  parameter int          START_ADDR     = 1,
  parameter logic [1:0]  MEM_FUNC_WRITE = 2'b01,
  parameter int          BYTES_PER_WORD = (DATA_W + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_owner,
  output logic              traversal_execute,
  output logic [ADDR_W-1:0] start_addr,
  output logic              loaded,
  output logic              error,
  output logic [15:0]       words_written
);

  localparam int BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);
  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [32:0] MAX_WORDS = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

  typedef enum logic [3:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_CHECK,
    S_COLLECT,
    S_WR_REQ,
    S_WR_BUSY,
    S_WR_DONE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [15:0]       n_words;
  logic [BCNT_W-1:0] byte_cnt;
  logic              transfer;
  logic [15:0]       ww_next;

  assign transfer = in_valid & in_ready;
  assign ww_next  = words_written + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_HDR_HI;
      n_words           <= '0;
      byte_cnt          <= '0;
      in_ready          <= 1'b0;
      mem_execute       <= 1'b0;
      mem_func          <= 2'b00;
      address           <= '0;
      write_data        <= '0;
      mem_owner         <= 1'b1;
      traversal_execute <= 1'b0;
      start_addr        <= '0;
      loaded            <= 1'b0;
      error             <= 1'b0;
      words_written     <= '0;
    end else begin
      case (state)
        S_HDR_HI: begin
          in_ready <= 1'b1;
          if (transfer) begin
            n_words[15:8] <= in_data;
            state         <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (transfer) begin
            n_words[7:0] <= in_data;
            in_ready     <= 1'b0;
            state        <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (33'(n_words) > MAX_WORDS) begin
            error <= 1'b1;
            state <= S_ERROR;
          end else if (n_words == 16'd0) begin
            mem_owner  <= 1'b0;
            start_addr <= ADDR_W'(START_ADDR);
            state      <= S_DONE;
          end else begin
            address  <= ADDR_W'(BASE_ADDR);
            byte_cnt <= '0;
            in_ready <= 1'b1;
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (transfer) begin
            // Shifting a full word of bytes through drops anything above DATA_W.
            write_data <= DATA_W'({write_data, in_data});
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt    <= '0;
              in_ready    <= 1'b0;
              mem_execute <= mem_ready;
              if (mem_ready) mem_func <= MEM_FUNC_WRITE;
              state       <= S_WR_REQ;
            end else begin
              byte_cnt <= byte_cnt + BCNT_W'(1);
            end
          end
        end
        S_WR_REQ: begin
          if (mem_execute) begin
            mem_execute <= 1'b0;
            state       <= S_WR_BUSY;
          end else if (mem_ready) begin
            mem_execute <= 1'b1;
            mem_func    <= MEM_FUNC_WRITE;
          end
        end
        S_WR_BUSY: begin
          if (!mem_ready) state <= S_WR_DONE;
        end
        S_WR_DONE: begin
          if (mem_ready) begin
            words_written <= ww_next;
            address       <= address + ADDR_W'(1);
            mem_func      <= 2'b00;
            if (ww_next == n_words) begin
              mem_owner  <= 1'b0;
              start_addr <= ADDR_W'(START_ADDR);
              state      <= S_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= S_COLLECT;
            end
          end
        end
        S_DONE: begin
          traversal_execute <= 1'b1;
          loaded            <= 1'b1;
        end
        S_ERROR: begin
          error <= 1'b1;
        end
        default: state <= S_HDR_HI;
      endcase
    end
  end

endmodule
